// File: rtl/mw_store_buffer_pkg.sv
// mw_store_buffer_pkg: shared widths, entry type and byte helpers for the MW store buffer
package mw_store_buffer_pkg;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int BE_W = DATA_W / 8;
   localparam int SB_DEPTH = 4;
   typedef logic [BE_W-1:0] be_t;
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      be_t be;
      logic v;
   } sb_entry_t;
   // Dword equality; bits [1:0] are masked rather than sliced so callers read the full address.
   function automatic logic same_dword(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
      return ~|((a ^ b) & ~ADDR_W'(3));
   endfunction
   function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_d, input logic [DATA_W-1:0] new_d, input be_t be);
      merge_bytes = old_d;
      for (int i = 0; i < BE_W; i++)
         if (be[i]) merge_bytes[i*8 +: 8] = new_d[i*8 +: 8];
   endfunction
endpackage

// File: rtl/mw_store_buffer_if.sv
// mw_store_buffer_if: MW write port, load-check port and memory drain port of the store buffer
//  master (MW stage / memory side): drives wr_*, ld_*, mem_ack; observes wr_stall, sb_dep, mem_*, sb_empty, sb_count
//  slave  (store buffer): the reverse
interface mw_store_buffer_if import mw_store_buffer_pkg::*; #(parameter int DEPTH = SB_DEPTH);
   logic wr_v;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   be_t wr_be;
   logic wr_stall;
   logic ld_v;
   logic [ADDR_W-1:0] ld_addr;
   logic sb_dep;
   logic mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;
   be_t mem_be;
   logic mem_ack;
   logic sb_empty;
   logic [$clog2(DEPTH):0] sb_count;
   modport master (
      output wr_v, wr_addr, wr_data, wr_be, ld_v, ld_addr, mem_ack,
      input wr_stall, sb_dep, mem_req, mem_addr, mem_data, mem_be, sb_empty, sb_count
   );
   modport slave (
      input wr_v, wr_addr, wr_data, wr_be, ld_v, ld_addr, mem_ack,
      output wr_stall, sb_dep, mem_req, mem_addr, mem_data, mem_be, sb_empty, sb_count
   );
endinterface

// File: rtl/mw_store_buffer_addr_match.sv
// sb_addr_match: per-entry dword address compare against one query address -> hit vector of valid entries
//  ent  in   buffer entries
//  addr in   query byte address (low 2 bits ignored)
//  hit  out  bit i set when entry i is valid and in the same dword
module sb_addr_match import mw_store_buffer_pkg::*; #(parameter int DEPTH = SB_DEPTH) (
   input sb_entry_t ent [DEPTH],
   input logic [ADDR_W-1:0] addr,
   output logic [DEPTH-1:0] hit
);
   always_comb begin
      hit = '0;
      for (int i = 0; i < DEPTH; i++) hit[i] = ent[i].v && same_dword(ent[i].addr, addr);
   end
endmodule

// File: rtl/mw_store_buffer.sv
// mw_store_buffer: in-order store queue between MW and data memory with load-hazard detection
//  clk, reset  clock and synchronous active-high reset
//  sb          slave side of mw_store_buffer_if: MW write (wr_*/wr_stall), load check (ld_*/sb_dep),
//              memory drain (mem_req/mem_addr/mem_data/mem_be/mem_ack), status (sb_empty/sb_count)
//  Optional: define SB_COALESCE_EN to merge a write into the youngest entry when it hits the same dword.
module mw_store_buffer import mw_store_buffer_pkg::*; #(parameter int DEPTH = SB_DEPTH) (
   input logic clk,
   input logic reset,
   mw_store_buffer_if.slave sb
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   sb_entry_t ent [DEPTH];
   logic [PW-1:0] head, tail;
   logic [CW-1:0] count;
   logic [DEPTH-1:0] hit_ld, be_nz;
   logic full, enq, deq, coal;
   sb_addr_match #(.DEPTH(DEPTH)) u_ld_match (.ent(ent), .addr(sb.ld_addr), .hit(hit_ld));
`ifdef SB_COALESCE_EN
   logic [DEPTH-1:0] hit_wr;
   logic [PW-1:0] yng;
   sb_addr_match #(.DEPTH(DEPTH)) u_wr_match (.ent(ent), .addr(sb.wr_addr), .hit(hit_wr));
   assign yng = tail - PW'(1);
   // The head may be mid-handshake with memory, so it is never a merge target while requested.
   assign coal = sb.wr_v && hit_wr[yng] && !(yng == head && sb.mem_req);
`else
   assign coal = 1'b0;
`endif
   // Full is from the registered count only: a same-cycle ack does not free a slot for the writer.
   assign full = count == CW'(DEPTH);
   assign sb.wr_stall = full && !coal;
   assign enq = sb.wr_v && !full && !coal;
   assign deq = sb.mem_req && sb.mem_ack;
   assign sb.mem_req = count != '0;
   assign sb.mem_addr = ent[head].addr;
   assign sb.mem_data = ent[head].data;
   assign sb.mem_be = ent[head].be;
   assign sb.sb_empty = count == '0;
   assign sb.sb_count = count;
   always_comb begin
      be_nz = '0;
      for (int i = 0; i < DEPTH; i++) be_nz[i] = |ent[i].be;
   end
   // Entries with no enabled bytes cannot conflict with a load.
   assign sb.sb_dep = sb.ld_v && |(hit_ld & be_nz);
   always_ff @(posedge clk) begin
      if (reset) begin
         head <= '0;
         tail <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) ent[i].v <= 1'b0;
      end else begin
         if (enq) begin
            ent[tail] <= '{addr: sb.wr_addr & ~ADDR_W'(3), data: sb.wr_data, be: sb.wr_be, v: 1'b1};
            tail <= tail + PW'(1);
         end
`ifdef SB_COALESCE_EN
         if (coal) begin
            ent[yng].data <= merge_bytes(ent[yng].data, sb.wr_data, sb.wr_be);
            ent[yng].be <= ent[yng].be | sb.wr_be;
         end
`endif
         if (deq) begin
            ent[head].v <= 1'b0;
            head <= head + PW'(1);
         end
         count <= count + CW'(enq) - CW'(deq);
      end
   end
endmodule

// File: tb/tb_mw_store_buffer.sv
// tb_mw_store_buffer: directed stimulus with a queue-based reference model and per-cycle output compare
module tb_mw_store_buffer;
   localparam int DEPTH = 4;
`ifdef SB_COALESCE_EN
   localparam bit COAL = 1'b1;
`else
   localparam bit COAL = 1'b0;
`endif
   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0] be;
   } ent_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int n_cmp = 0;
   int n_bad = 0;
   ent_t q[$];
   mw_store_buffer_if #(.DEPTH(DEPTH)) bus();
   mw_store_buffer #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .sb(bus));
   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
      end
   endtask

   function automatic bit coal_now();
`ifdef SB_COALESCE_EN
      return bus.wr_v && q.size() > 1 && q[$].a[31:2] == bus.wr_addr[31:2];
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit dep_now();
      bit r = 1'b0;
      foreach (q[i]) if (q[i].a[31:2] == bus.ld_addr[31:2] && q[i].be != 4'h0) r = 1'b1;
      return bus.ld_v && r;
   endfunction

   // Reference model: a plain FIFO of stores, updated on each rising edge.
   always @(posedge clk) begin
      bit c, s, d;
      if (reset) q.delete();
      else begin
         c = coal_now();
         s = q.size() == DEPTH && !c;
         d = q.size() > 0 && bus.mem_ack;
         if (c) begin
            for (int b = 0; b < 4; b++) if (bus.wr_be[b]) q[$].d[b*8 +: 8] = bus.wr_data[b*8 +: 8];
            q[$].be = q[$].be | bus.wr_be;
         end else if (bus.wr_v && !s) q.push_back('{a: {bus.wr_addr[31:2], 2'b00}, d: bus.wr_data, be: bus.wr_be});
         if (d) void'(q.pop_front());
      end
   end

   initial forever begin
      @(negedge clk);
      #2;
      chk("wr_stall", 32'(bus.wr_stall), 32'(q.size() == DEPTH && !coal_now()));
      chk("mem_req", 32'(bus.mem_req), 32'(q.size() > 0));
      chk("sb_empty", 32'(bus.sb_empty), 32'(q.size() == 0));
      chk("sb_count", 32'(bus.sb_count), 32'(q.size()));
      chk("sb_dep", 32'(bus.sb_dep), 32'(dep_now()));
      if (q.size() > 0) begin
         chk("mem_addr", bus.mem_addr, q[0].a);
         chk("mem_data", bus.mem_data, q[0].d);
         chk("mem_be", 32'(bus.mem_be), 32'(q[0].be));
      end
   end

   task automatic step(input bit wv, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                       input bit lv, input logic [31:0] la, input bit ack);
      @(negedge clk);
      bus.wr_v = wv;
      bus.wr_addr = a;
      bus.wr_data = d;
      bus.wr_be = be;
      bus.ld_v = lv;
      bus.ld_addr = la;
      bus.mem_ack = ack;
      #1;
   endtask

   task automatic idle();
      step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
   endtask

   initial begin
      logic [31:0] order [4];
      order[0] = 32'h14;
      order[1] = 32'h18;
      order[2] = 32'h1C;
      order[3] = 32'h20;
      bus.wr_v = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      bus.wr_be = '0;
      bus.ld_v = 1'b0;
      bus.ld_addr = '0;
      bus.mem_ack = 1'b0;
      idle();
      idle();
      reset = 1'b0;
      idle();
      chk("rst_empty", 32'(bus.sb_empty), 32'd1);
      chk("rst_count", 32'(bus.sb_count), 32'd0);
      chk("rst_req", 32'(bus.mem_req), 32'd0);
      chk("rst_stall", 32'(bus.wr_stall), 32'd0);
      // single store held without ack
      step(1'b1, 32'h1000, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 1'b0);
      chk("t1_no_bypass", 32'(bus.mem_req), 32'd0);
      repeat (5) begin
         idle();
         chk("t1_req", 32'(bus.mem_req), 32'd1);
         chk("t1_addr", bus.mem_addr, 32'h1000);
         chk("t1_data", bus.mem_data, 32'hDEADBEEF);
         chk("t1_be", 32'(bus.mem_be), 32'hF);
      end
      step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1);
      idle();
      chk("t1_empty", 32'(bus.sb_empty), 32'd1);
      chk("t1_count", 32'(bus.sb_count), 32'd0);
      // fill, stall, ack does not unblock in the same cycle
      for (int i = 0; i < 4; i++) step(1'b1, 32'h10 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF, 1'b0, 32'h0, 1'b0);
      step(1'b1, 32'h20, 32'hB5, 4'hF, 1'b0, 32'h0, 1'b0);
      chk("t2_stall", 32'(bus.wr_stall), 32'd1);
      chk("t2_full", 32'(bus.sb_count), 32'd4);
      step(1'b1, 32'h20, 32'hB5, 4'hF, 1'b0, 32'h0, 1'b1);
      chk("t2_stall_ack", 32'(bus.wr_stall), 32'd1);
      chk("t2_order0", bus.mem_addr, 32'h10);
      step(1'b1, 32'h20, 32'hB5, 4'hF, 1'b0, 32'h0, 1'b0);
      chk("t2_unstall", 32'(bus.wr_stall), 32'd0);
      chk("t2_count3", 32'(bus.sb_count), 32'd3);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1);
         chk("t2_order", bus.mem_addr, order[i]);
      end
      idle();
      chk("t2_empty", 32'(bus.sb_empty), 32'd1);
      // load hazard against a queued store
      step(1'b1, 32'h2000, 32'h1, 4'hF, 1'b0, 32'h0, 1'b0);
      step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h2003, 1'b0);
      chk("t3_dep_hit", 32'(bus.sb_dep), 32'd1);
      step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h2004, 1'b0);
      chk("t3_dep_next", 32'(bus.sb_dep), 32'd0);
      step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h2003, 1'b1);
      chk("t3_dep_acking", 32'(bus.sb_dep), 32'd1);
      step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h2003, 1'b0);
      chk("t3_dep_drained", 32'(bus.sb_dep), 32'd0);
      // incoming write is not compared in its own cycle
      step(1'b1, 32'h4000, 32'h2, 4'hF, 1'b1, 32'h4000, 1'b0);
      chk("t4_dep_same", 32'(bus.sb_dep), 32'd0);
      step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h4000, 1'b0);
      chk("t4_dep_next", 32'(bus.sb_dep), 32'd1);
      step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1);
      // zero byte-enable store is queued but never a hazard
      step(1'b1, 32'h4800, 32'h3, 4'h0, 1'b0, 32'h0, 1'b0);
      step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h4800, 1'b0);
      chk("t4_be0_dep", 32'(bus.sb_dep), 32'd0);
      chk("t4_be0_count", 32'(bus.sb_count), 32'd1);
      step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1);
      idle();
      // reset mid-drain
      for (int i = 0; i < 3; i++) step(1'b1, 32'h50 + 32'(4 * i), 32'hC0 + 32'(i), 4'hF, 1'b0, 32'h0, 1'b0);
      idle();
      chk("t5_count", 32'(bus.sb_count), 32'd3);
      reset = 1'b1;
      idle();
      reset = 1'b0;
      step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h50, 1'b0);
      chk("t5_req", 32'(bus.mem_req), 32'd0);
      chk("t5_empty", 32'(bus.sb_empty), 32'd1);
      chk("t5_dep", 32'(bus.sb_dep), 32'd0);
      // coalescing into the youngest non-head entry
      step(1'b1, 32'h6000, 32'h11111111, 4'hF, 1'b0, 32'h0, 1'b0);
      step(1'b1, 32'h3000, 32'h000000AA, 4'h1, 1'b0, 32'h0, 1'b0);
      step(1'b1, 32'h3000, 32'h0000BB00, 4'h2, 1'b0, 32'h0, 1'b0);
      idle();
      chk("t6_count", 32'(bus.sb_count), COAL ? 32'd2 : 32'd3);
      step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1);
      idle();
      chk("t6_addr", bus.mem_addr, 32'h3000);
      chk("t6_be", 32'(bus.mem_be), COAL ? 32'h3 : 32'h1);
      chk("t6_data", bus.mem_data, COAL ? 32'h0000BBAA : 32'h000000AA);
      repeat (2) step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1);
      idle();
      chk("t6_empty", 32'(bus.sb_empty), 32'd1);
      idle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
